chip8_display: RTL and testbench

- Executes one sprite row of the CHIP-8 DXYN draw instruction against a 64x32, 1-bit-per-pixel framebuffer held in external byte-wide memory (256 bytes).
- Reads the affected framebuffer byte(s), XORs in the sprite row, writes the result back and reports pixel collision.
- Sits between the CPU execute unit, which issues one `draw` per sprite row, and the display RAM.

---
 rtl/chip8_pkg.sv | 27 ++
 rtl/chip8_display_if.sv | 31 +++
 rtl/chip8_sprite_shift.sv | 20 ++
 rtl/chip8_display.sv | 112 +++++++++++
 tb/tb_chip8_display.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/chip8_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | chip8_pkg : CHIP-8 framebuffer geometry, draw FSM states, addr helper |
// | Revision  : 1.0                                                       |
// +-----------------------------------------------------------------------+
package chip8_pkg;

    localparam int DISP_W    = 64;
    localparam int DISP_H    = 32;
    localparam int ROW_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        WR0  = 3'd2,
        RD1  = 3'd3,
        WR1  = 3'd4,
        DONE = 3'd5
    } state_e;

    // row*8 + byte column; both operands already wrapped by their widths
    function automatic logic [7:0] fb_addr(input logic [4:0] row, input logic [2:0] cb);
        return {row, cb};
    endfunction

endpackage
`default_nettype wire

// File: rtl/chip8_display_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | chip8_display_if : draw request, completion and display RAM signals   |
// | Revision         : 1.0                                                |
// +-----------------------------------------------------------------------+
interface chip8_display_if;

    logic       draw;
    logic [5:0] x;
    logic [4:0] y;
    logic [3:0] row_index;
    logic [7:0] sprite_data;
    logic [7:0] display_in;
    logic [7:0] display_out;
    logic       display_we;
    logic [7:0] addr;
    logic       collision;
    logic       done;

    modport master (
        output draw, x, y, row_index, sprite_data, display_in,
        input  display_out, display_we, addr, collision, done
    );

    modport slave (
        input  draw, x, y, row_index, sprite_data, display_in,
        output display_out, display_we, addr, collision, done
    );

endinterface
`default_nettype wire

// File: rtl/chip8_sprite_shift.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | chip8_sprite_shift : split a sprite row across two framebuffer bytes  |
// | Revision           : 1.0                                              |
// +-----------------------------------------------------------------------+
module chip8_sprite_shift (
    input  logic [7:0] sprite_data_i,
    input  logic [2:0] shift_i,
    output logic [7:0] hi_o,
    output logic [7:0] lo_o
);

    logic [15:0] w_shifted;

    assign w_shifted = {sprite_data_i, 8'h00} >> shift_i;
    assign hi_o      = w_shifted[15:8];
    assign lo_o      = w_shifted[7:0];

endmodule
`default_nettype wire

// File: rtl/chip8_display.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | chip8_display : one DXYN sprite row read-XOR-write with collision     |
// | Revision      : 1.0                                                   |
// +-----------------------------------------------------------------------+
module chip8_display
    import chip8_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    chip8_display_if.slave   bus
);

    state_e     state_q;
    logic [4:0] row_q;
    logic [2:0] cb_q;
    logic [2:0] shift_q;
    logic [7:0] hi_q;
    logic [7:0] lo_q;
    logic [7:0] addr_q;
    logic [7:0] dout_q;
    logic       we_q;
    logic       coll_q;
    logic       done_q;

    logic [4:0] row_d;
    logic [7:0] hi_d;
    logic [7:0] lo_d;

    assign row_d = bus.y + 5'(bus.row_index);

    chip8_sprite_shift u_shift (
        .sprite_data_i (bus.sprite_data),
        .shift_i       (bus.x[2:0]),
        .hi_o          (hi_d),
        .lo_o          (lo_d)
    );

    // Outputs are set on the edge that enters a state, so each RD cycle
    // presents the address and the following WR cycle carries the data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            cb_q    <= '0;
            shift_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            we_q    <= 1'b0;
            coll_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.draw) begin
                        row_q   <= row_d;
                        cb_q    <= bus.x[5:3];
                        shift_q <= bus.x[2:0];
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        coll_q  <= 1'b0;
                        addr_q  <= fb_addr(row_d, bus.x[5:3]);
                        state_q <= RD0;
                    end
                end
                RD0: begin
                    dout_q  <= bus.display_in ^ hi_q;
                    we_q    <= 1'b1;
                    coll_q  <= coll_q | (|(bus.display_in & hi_q));
                    state_q <= WR0;
                end
                WR0: begin
                    if (shift_q != 3'd0) begin
                        addr_q  <= fb_addr(row_q, cb_q + 3'd1);
                        state_q <= RD1;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                RD1: begin
                    dout_q  <= bus.display_in ^ lo_q;
                    we_q    <= 1'b1;
                    coll_q  <= coll_q | (|(bus.display_in & lo_q));
                    state_q <= WR1;
                end
                WR1: begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.addr        = addr_q;
    assign bus.display_out = dout_q;
    assign bus.display_we  = we_q;
    assign bus.collision   = coll_q;
    assign bus.done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_chip8_display.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_chip8_display : directed draws against a pixel-level framebuffer   |
// | Revision         : 1.0                                                |
// +-----------------------------------------------------------------------+
module tb_chip8_display;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    wr_t  exp_q[$];
    bit   exp_coll_q[$];
    int   exp_lat_q[$];

    logic [7:0] mem    [256] = '{default: 8'h00};
    logic [7:0] ref_fb [256];
    logic       pl_we;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;

    chip8_display_if bus ();

    chip8_display dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Display RAM: combinational read, write on the rising edge
    always @(posedge clk) begin
        if (pl_we)
            mem[pl_addr] <= pl_data;
        else if (bus.display_we)
            mem[bus.addr] <= bus.display_out;
    end
    assign bus.display_in = mem[bus.addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); @(negedge clk);
        pl_we = 1'b0;
        ref_fb[a] = d;
    endtask

    task automatic scramble();
        bus.x           = 6'($urandom);
        bus.y           = 5'($urandom);
        bus.row_index   = 4'($urandom);
        bus.sprite_data = 8'($urandom);
    endtask

    // Pixel-by-pixel model: flip each set sprite pixel at (x+i) mod 64
    task automatic expect_draw(input logic [5:0] xx, input logic [4:0] yy, input logic [3:0] ri,
                               input logic [7:0] spr, input bit abort);
        int row, b0, b1, c, bi;
        logic [7:0] v0, v1;
        bit coll, unaligned;
        coll      = 1'b0;
        row       = (int'(yy) + int'(ri)) % 32;
        b0        = row * 8 + int'(xx) / 8;
        b1        = row * 8 + (int'(xx) / 8 + 1) % 8;
        unaligned = (xx[2:0] != 3'd0);
        v0        = ref_fb[b0];
        v1        = ref_fb[b1];
        for (int i = 0; i < 8; i++) begin
            if (spr[7-i]) begin
                c  = (int'(xx) + i) % 64;
                bi = 7 - (c % 8);
                if (row * 8 + c / 8 == b0) begin
                    coll   = coll | v0[bi];
                    v0[bi] = ~v0[bi];
                end else begin
                    coll   = coll | v1[bi];
                    v1[bi] = ~v1[bi];
                end
            end
        end
        exp_q.push_back('{a: 8'(b0), d: v0});
        ref_fb[b0] = v0;
        if (unaligned && !abort) begin
            exp_q.push_back('{a: 8'(b1), d: v1});
            ref_fb[b1] = v1;
        end
        if (!abort) begin
            exp_coll_q.push_back(coll);
            exp_lat_q.push_back(unaligned ? 5 : 3);
        end
    endtask

    task automatic check_write(input string tag);
        wr_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 32'(bus.addr), 32'hFFFF);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_addr"}, 32'(bus.addr), 32'(e.a));
            check({tag, "_data"}, 32'(bus.display_out), 32'(e.d));
        end
    endtask

    task automatic run_draw(input logic [5:0] xx, input logic [4:0] yy, input logic [3:0] ri,
                            input logic [7:0] spr, input bit hold);
        int edges;
        bit seen;
        expect_draw(xx, yy, ri, spr, 1'b0);
        bus.x = xx; bus.y = yy; bus.row_index = ri; bus.sprite_data = spr;
        bus.draw = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        if (!hold) bus.draw = 1'b0;
        scramble();
        seen = 1'b0;
        while (!seen && edges <= 12) begin
            if (bus.display_we) check_write("write");
            if (bus.done) begin
                seen = 1'b1;
                check("latency", 32'(edges), 32'(exp_lat_q.pop_front()));
                check("collision", 32'(bus.collision), 32'(exp_coll_q.pop_front()));
                check("writes_drained", 32'(exp_q.size()), 32'd0);
            end else begin
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
            exp_q.delete(); exp_lat_q.delete(); exp_coll_q.delete();
        end
        @(posedge clk); @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("idle_no_write", 32'(bus.display_we), 32'd0);
    endtask

    initial begin
        int diff;
        errors = 0; checks = 0;
        clk = 1'b0; reset = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        bus.draw = 1'b0; bus.x = 6'd10; bus.y = 5'd4; bus.row_index = '0; bus.sprite_data = 8'hF0;
        for (int i = 0; i < 256; i++) ref_fb[i] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr", 32'(bus.addr), 32'd0);
        check("rst_dout", 32'(bus.display_out), 32'd0);
        check("rst_we", 32'(bus.display_we), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_coll", 32'(bus.collision), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Unaligned draw over a partly set background
        poke(8'h21, 8'h0F);
        poke(8'h22, 8'h0F);
        run_draw(6'd10, 5'd4, 4'd0, 8'hF0, 1'b0);

        // Aligned draw: single read/write pair
        run_draw(6'd0, 5'd0, 4'd0, 8'hAA, 1'b0);

        // Vertical and horizontal wrap on a clear background
        poke(8'h00, 8'h00);
        run_draw(6'd62, 5'd31, 4'd1, 8'hFF, 1'b0);

        // Reset while the second byte is being read
        expect_draw(6'd13, 5'd7, 4'd2, 8'hC3, 1'b1);
        bus.x = 6'd13; bus.y = 5'd7; bus.row_index = 4'd2; bus.sprite_data = 8'hC3;
        bus.draw = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.draw = 1'b0;
        scramble();
        check("abort_rd0_we", 32'(bus.display_we), 32'd0);
        @(posedge clk); @(negedge clk);
        check("abort_wr0_we", 32'(bus.display_we), 32'd1);
        check_write("abort_wr0");
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_addr", 32'(bus.addr), 32'd0);
        check("abort_dout", 32'(bus.display_out), 32'd0);
        check("abort_we", 32'(bus.display_we), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_coll", 32'(bus.collision), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_no_done", 32'(bus.done), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_no_done_after", 32'(bus.done), 32'd0);
        run_draw(6'd13, 5'd7, 4'd2, 8'h81, 1'b0);

        // draw held high: colliding draw, then an independent one
        poke(8'h52, 8'h01);
        run_draw(6'd16, 5'd10, 4'd0, 8'hFF, 1'b1);
        run_draw(6'd40, 5'd20, 4'd3, 8'h18, 1'b0);

        @(posedge clk); @(negedge clk);
        diff = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_fb[i]) diff++;
        check("framebuffer_bytes_differing", 32'(diff), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
